// File: rtl/register_scoreboard_pkg.sv
// Shared types for the ID-stage scoreboard and the forwarding selector:
// register index, per-register status code and in-flight writer slot.
package register_scoreboard_pkg;

    localparam int unsigned NREG = 8;
    localparam int unsigned RW   = 3;

    typedef logic [RW-1:0] reg_idx_t;

    typedef enum logic [2:0] {
        RS_VALID    = 3'd0,
        RS_EX       = 3'd1,
        RS_FWD_MEM  = 3'd2,
        RS_FWD_WB   = 3'd3,
        RS_LOAD_MEM = 3'd4
    } reg_status_e;

    typedef struct packed {
        logic     v;
        reg_idx_t rd;
        logic     ld;
    } sb_slot_t;

    // Codes whose value cannot be forwarded yet; a consumer must wait.
    function automatic logic is_stall_code(input reg_status_e code);
        return (code == RS_EX) || (code == RS_LOAD_MEM);
    endfunction

endpackage

// File: rtl/register_scoreboard_status_decode.sv
// Status of one register index, taken from the youngest matching in-flight
// writer (ex > mem > wb).
module sb_status_decode
    import register_scoreboard_pkg::*;
(
    input  sb_slot_t    ex_slot,
    input  sb_slot_t    mem_slot,
    input  sb_slot_t    wb_slot,
    input  reg_idx_t    idx,
    output reg_status_e status
);

    always_comb begin
        status = RS_VALID;
        if (ex_slot.v && (ex_slot.rd == idx)) begin
            status = RS_EX;
        end else if (mem_slot.v && (mem_slot.rd == idx)) begin
            status = mem_slot.ld ? RS_LOAD_MEM : RS_FWD_MEM;
        end else if (wb_slot.v && (wb_slot.rd == idx)) begin
            status = RS_FWD_WB;
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// Tracks destination registers of writers in EX/MEM/WB, publishes a status
// code per register for the forwarding selector and raises the ID hazard stall.
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned RW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic                 id_wr,
    input  logic [RW-1:0]        id_rd,
    input  logic                 id_load,
    input  logic                 use_ra,
    input  logic                 use_rb,
    input  logic [RW-1:0]        ra,
    input  logic [RW-1:0]        rb,
    input  logic                 hold,
    input  logic                 flush,
    output logic [NREG-1:0][2:0] register_invalid,
    output logic                 hazard_stall
);

    sb_slot_t    ex_q,  ex_d;
    sb_slot_t    mem_q, mem_d;
    sb_slot_t    wb_q,  wb_d;
    reg_status_e code_ra, code_rb;
    logic        issue_wr;

    for (genvar r = 0; r < NREG; r++) begin : g_reg_status
        reg_status_e code_r;
        sb_status_decode u_decode (
            .ex_slot  (ex_q),
            .mem_slot (mem_q),
            .wb_slot  (wb_q),
            .idx      (reg_idx_t'(r)),
            .status   (code_r)
        );
        assign register_invalid[r] = code_r;
    end

    sb_status_decode u_decode_ra (
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .idx      (ra),
        .status   (code_ra)
    );

    sb_status_decode u_decode_rb (
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .idx      (rb),
        .status   (code_rb)
    );

    // A flushed ID instruction dies anyway, so it never stalls.
    always_comb begin
        hazard_stall = id_valid && !flush &&
                       ((use_ra && is_stall_code(code_ra)) ||
                        (use_rb && is_stall_code(code_rb)));
        issue_wr     = id_valid && id_wr && !hazard_stall && !flush;
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hold) begin
            wb_d     = mem_q;
            mem_d    = ex_q;
            mem_d.v  = ex_q.v && !flush;
            ex_d.v   = issue_wr;
            ex_d.rd  = id_rd;
            ex_d.ld  = id_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with hand-computed status codes.
module tb_register_scoreboard;

    logic            clk;
    logic            rst_n;
    logic            id_valid, id_wr, id_load;
    logic [2:0]      id_rd;
    logic            use_ra, use_rb;
    logic [2:0]      ra, rb;
    logic            hold, flush;
    logic [7:0][2:0] register_invalid;
    logic            hazard_stall;

    int n_checks;
    int n_bad;

    register_scoreboard #(.NREG(8), .RW(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_wr            (id_wr),
        .id_rd            (id_rd),
        .id_load          (id_load),
        .use_ra           (use_ra),
        .use_rb           (use_rb),
        .ra               (ra),
        .rb               (rb),
        .hold             (hold),
        .flush            (flush),
        .register_invalid (register_invalid),
        .hazard_stall     (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int code(input int r);
        return int'(register_invalid[r]);
    endfunction

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_r%0d", tag, i), code(i), 0);
        end
    endtask

    task automatic set_id(input logic v, input logic w, input int rd, input logic ld,
                          input logic ua, input int a, input logic ub, input int b);
        id_valid = v;
        id_wr    = w;
        id_rd    = 3'(rd);
        id_load  = ld;
        use_ra   = ua;
        ra       = 3'(a);
        use_rb   = ub;
        rb       = 3'(b);
    endtask

    task automatic idle();
        set_id(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    // Advance past the next rising edge; inputs change here, checks at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        idle();

        // Reset / idle
        repeat (2) @(posedge clk);
        settle();
        check_all_zero("rst_low");
        rst_n = 1'b1;
        tick();
        set_id(1'b1, 1'b0, 0, 1'b0, 1'b1, 0, 1'b1, 7);
        settle();
        check_all_zero("idle");
        check("idle_stall", int'(hazard_stall), 0);

        // ALU chain on r3
        tick();
        set_id(1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 0);
        tick();
        set_id(1'b1, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 0);
        settle();
        check("alu_c1_code", code(3), 1);
        check("alu_c1_stall", int'(hazard_stall), 1);
        tick();
        settle();
        check("alu_c2_code", code(3), 2);
        check("alu_c2_stall", int'(hazard_stall), 0);
        tick();
        idle();
        settle();
        check("alu_c3_code", code(3), 3);
        tick();
        settle();
        check("alu_c4_code", code(3), 0);

        // Load-use on r5; the stalled consumer writes r6
        tick();
        set_id(1'b1, 1'b1, 5, 1'b1, 1'b0, 0, 1'b0, 0);
        tick();
        set_id(1'b1, 1'b1, 6, 1'b0, 1'b0, 0, 1'b1, 5);
        settle();
        check("ld_c1_code", code(5), 1);
        check("ld_c1_stall", int'(hazard_stall), 1);
        tick();
        settle();
        check("ld_c2_code", code(5), 4);
        check("ld_c2_stall", int'(hazard_stall), 1);
        check("ld_c2_bubble", code(6), 0);
        tick();
        settle();
        check("ld_c3_code", code(5), 3);
        check("ld_c3_stall", int'(hazard_stall), 0);
        check("ld_c3_bubble", code(6), 0);
        tick();
        idle();
        settle();
        check("ld_c4_consumer", code(6), 1);
        repeat (3) tick();
        settle();
        check_all_zero("ld_drain");

        // WAW on r2
        tick();
        set_id(1'b1, 1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 0);
        tick();
        tick();
        idle();
        settle();
        check("waw_c2", code(2), 1);
        tick();
        settle();
        check("waw_c3", code(2), 2);
        tick();
        settle();
        check("waw_c4", code(2), 3);
        tick();
        settle();
        check("waw_c5", code(2), 0);

        // Hold then flush, writer r4 in EX; ID tries to write r7 throughout
        tick();
        set_id(1'b1, 1'b1, 4, 1'b0, 1'b0, 0, 1'b0, 0);
        tick();
        set_id(1'b1, 1'b1, 7, 1'b0, 1'b0, 0, 1'b0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) flush = 1'b1;
            settle();
            check($sformatf("hold_%0d_code4", i), code(4), 1);
            tick();
        end
        settle();
        check("hold_after_code4", code(4), 1);
        check("hold_after_code7", code(7), 0);
        hold  = 1'b0;
        flush = 1'b1;
        set_id(1'b1, 1'b1, 7, 1'b0, 1'b1, 4, 1'b0, 0);
        #1;
        check("flush_stall", int'(hazard_stall), 0);
        tick();
        idle();
        settle();
        check("flush_code4", code(4), 0);
        check("flush_code7", code(7), 0);

        // Async reset with all slots full
        tick();
        set_id(1'b1, 1'b1, 1, 1'b0, 1'b0, 0, 1'b0, 0);
        tick();
        set_id(1'b1, 1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 0);
        tick();
        set_id(1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 0);
        tick();
        idle();
        settle();
        check("full_wb", code(1), 3);
        check("full_mem", code(2), 2);
        check("full_ex", code(3), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        settle();
        check_all_zero("post_rst");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
- Producer side of the ID-stage operand-forwarding scheme.
- Tracks the destination register of every in-flight writer in EX, MEM and WB, and publishes a per-register 3-bit status vector, register_invalid[7:0], that the forwarding selector consumes.
- Also raises the load-use / not-yet-computed hazard stall for the ID stage.
- Sits beside the decoder and pipeline control of the 16-bit, 8-register core.

Parameters:
- NREG, 8, number of architectural registers.
- RW, 3, register index width (log2 NREG).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_wr  in  1  ID instruction writes a register
- id_rd  in  RW  destination register of the ID instruction
- id_load  in  1  ID instruction is a load (result available only after MEM)
- use_ra  in  1  ID instruction reads ra
- use_rb  in  1  ID instruction reads rb
- ra  in  RW  source register A index
- rb  in  RW  source register B index
- hold  in  1  global pipeline freeze (e.g. memory wait); all stages hold
- flush  in  1  branch taken; kill the instruction in ID and the one in EX
- register_invalid  out  [7:0] x 3  per-register status code
- hazard_stall  out  1  ID must stall; a bubble is injected into EX

Behaviour:
- State: three slot registers, ex/mem/wb, each {v, rd[RW-1:0], ld}.
- All slot v bits clear on rst_n low, asynchronously. Other slot fields do not matter.
- Outputs are combinational from slot state and the ID inputs. There is no extra output latency.
- Status codes per register r, taken from the youngest matching slot (priority ex > mem > wb):
  - 0: no in-flight writer; register file value is current.
  - 1: ALU writer in EX; result not latched; consumer stalls.
  - 2: writer in MEM, non-load; EX/MEM latch holds the result; forward select 1.
  - 3: writer in WB; MEM/WB latch holds the result; forward select 2.
  - 4: load in MEM; data not yet returned; consumer stalls.
  - Codes 5–7 are never driven.
  - A load in EX reports 1. A load in WB reports 3.
- hazard_stall = id_valid & ((use_ra & code[ra] ∈ {1,4}) | (use_rb & code[rb] ∈ {1,4})).
- hazard_stall is forced to 0 while flush=1 (the ID instruction dies anyway).
- Update on rising clk, in priority order:
  - If hold=1: all slots keep their value. hold dominates flush; flush is not accepted during hold.
  - Else:
    - wb <= mem.
    - mem <= ex, with mem.v cleared if flush=1 (the EX instruction is killed).
    - ex <= {id_valid & id_wr & ~hazard_stall & ~flush, id_rd, id_load}.
  - The old wb slot retires; its writeback lands in the register file that same edge. Its code returns to 0 on the next cycle unless a younger slot matches.
- Multiple writers to the same rd: the youngest wins. A WAW pair in mem and wb reports 2 (or 4 for a load in mem).
- A stalled ID instruction re-presents the same inputs next cycle. The scoreboard keeps no ID-side state.
- Reset mid-operation: all slots are cleared immediately and every code reads 0 while rst_n is low.

Decomposition:
- Shared core package holds:
  - typedef reg_idx_t (logic [RW-1:0]);
  - enum reg_status_e {RS_VALID=0, RS_EX=1, RS_FWD_MEM=2, RS_FWD_WB=3, RS_LOAD_MEM=4};
  - struct sb_slot_t {v, rd, ld}.
- The forwarding selector imports the same enum.
- One natural sub-module: sb_status_decode. It is combinational: slots plus register index in, reg_status_e out. It is instantiated per register and again for ra/rb.

Test Plan:
- Reset/idle: rst_n=0 then 1, no issue.
  - Required: all 8 codes = 0; hazard_stall = 0.
- ALU chain: issue add r3 at cycle 0, no hold.
  - Required: code[3] = 1, 2, 3, 0 on cycles 1, 2, 3, 4.
  - Cycle 1 with use_ra, ra=3 gives hazard_stall=1; cycle 2 gives hazard_stall=0.
- Load-use: issue load r5 at cycle 0; consumer with rb=5, use_rb at cycles 1–2.
  - Required: code[5] = 1 then 4; hazard_stall=1 in both cycles; ex.v=0 after each stalled edge.
  - Cycle 3: code[5]=3, stall drops.
- WAW: write r2 at cycles 0 and 1.
  - Required: cycle 2 code[2] = 1 (younger in EX).
  - Cycle 3: code[2] = 2.
  - Cycle 4: code[2] = 3.
  - Cycle 5: code[2] = 0.
- Hold and flush:
  - Writer r4 in EX, hold=1 for 3 cycles: code[4] stays 1.
  - Then flush=1 with hold=0: mem.v=0, code[4]=0 next cycle, and the ID write is not entered.
- Async reset mid-flight: slots full; rst_n falls between clock edges.
  - Required: all codes are 0 before the next edge.
